// File: rtl/exe_mult_unit.sv
// exe_mult_unit: multi-cycle shift-add multiplier for the EXE stage.
// Computes a 2*WORD_LEN-bit product into HI/LO. It processes one multiplier bit
// per cycle and holds busy while running, so the hazard unit can stall the pipe.
// Optional feature macro: MULT_SIGNED_EN adds the is_signed port, which selects
// two's-complement operands (magnitude multiply followed by a conditional negate).
module exe_mult_unit #(
  parameter int unsigned WORD_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_LEN-1:0] val1,
  input  logic [WORD_LEN-1:0] val2,
  input  logic                flush,
`ifdef MULT_SIGNED_EN
  input  logic                is_signed,
`endif
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo
);

  localparam int unsigned PROD_W = 2 * WORD_LEN;
  localparam int unsigned CNT_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] mcand_q, mcand_d;
  logic [WORD_LEN-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                neg_q, neg_d;
  logic [WORD_LEN-1:0] hi_q, hi_d;
  logic [WORD_LEN-1:0] lo_q, lo_d;

  logic                last_iter_c;
  logic                accept_c;
  logic                commit_c;
  logic [WORD_LEN-1:0] mag1_c, mag2_c;
  logic                neg_req_c;
  logic [WORD_LEN:0]   sum_c;
  logic [PROD_W:0]     step_c;
  logic [PROD_W-1:0]   acc_next_c;
  logic [PROD_W-1:0]   result_c;

  // Control qualifiers: a new request is taken only when idle or committing, and flush always wins
  always_comb begin
    last_iter_c = (count_q == CNT_W'(WORD_LEN - 1));
    accept_c    = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));
    commit_c    = (state_q == S_RUN) && !flush && last_iter_c;
  end

  // Operand conditioning: signed mode multiplies magnitudes and remembers the result sign
  always_comb begin
    mag1_c    = val1;
    mag2_c    = val2;
    neg_req_c = 1'b0;
`ifdef MULT_SIGNED_EN
    if (is_signed) begin
      if (val1[WORD_LEN-1]) mag1_c = ~val1 + WORD_LEN'(1);
      if (val2[WORD_LEN-1]) mag2_c = ~val2 + WORD_LEN'(1);
      neg_req_c = val1[WORD_LEN-1] ^ val2[WORD_LEN-1];
    end
`endif
  end

  // One shift-add step: add multiplicand into the upper half, then shift right keeping the carry
  always_comb begin
    sum_c      = {1'b0, acc_q[PROD_W-1:WORD_LEN]}
               + {1'b0, (mplier_q[0] ? mcand_q : {WORD_LEN{1'b0}})};
    step_c     = {sum_c, acc_q[WORD_LEN-1:0]};
    acc_next_c = step_c[PROD_W:1];
    result_c   = neg_q ? (~acc_next_c + PROD_W'(1)) : acc_next_c;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_c) state_d = S_RUN;
      S_RUN: begin
        if (flush)            state_d = S_IDLE;
        else if (last_iter_c) state_d = S_DONE;
      end
      S_DONE:  state_d = accept_c ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: decoded directly from the state register
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath next-state: latch on accept, iterate in RUN, load HI/LO only at commit
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept_c) begin
      mcand_d  = mag1_c;
      mplier_d = mag2_c;
      acc_d    = '0;
      count_d  = '0;
      neg_d    = neg_req_c;
    end else if (state_q == S_RUN) begin
      acc_d    = acc_next_c;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
    end
    if (commit_c) begin
      hi_d = result_c[PROD_W-1:WORD_LEN];
      lo_d = result_c[WORD_LEN-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_exe_mult_unit.sv
// Directed testbench for exe_mult_unit (WORD_LEN=16); signed cases run when MULT_SIGNED_EN is defined.
module tb_exe_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] val1;
  logic [15:0] val2;
  logic        flush;
`ifdef MULT_SIGNED_EN
  logic        is_signed;
`endif
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;

  int vectors    = 0;
  int miscompares = 0;

  exe_mult_unit #(.WORD_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .val1      (val1),
    .val2      (val2),
    .flush     (flush),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  // Called at a negedge: present one request for one edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    val1  = a;
    val2  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and returns at the first non-busy negedge
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; val1 = '0; val2 = '0;
`ifdef MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ctl: busy/done got %b want 00", {busy, done});
    end
    vectors++;
    if ({hi, lo} !== 32'h0) begin
      miscompares++; $display("FAIL reset_hilo: got %h want 00000000", {hi, lo});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc;
    issue(16'd3, 16'd5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_rise: got %b want 1", busy);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 16) begin
      miscompares++; $display("FAIL basic_latency: got %0d want 16", cyc);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++; $display("FAIL basic_done: got %b want 1", done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0000_000F) begin
      miscompares++; $display("FAIL basic_product: got %h want 0000000f", {hi, lo});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL basic_done_pulse: busy/done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_zero;
    int cyc;
    issue(16'h0000, 16'hABCD);
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || done !== 1'b1) begin
      miscompares++; $display("FAIL zero_latency: got %0d done=%b want 16 done=1", cyc, done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0) begin
      miscompares++; $display("FAIL zero_product: got %h want 00000000", {hi, lo});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(16'hFFFF, 16'hFFFF);
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first_latency: got %0d done=%b want 16 done=1", cyc, done);
    end
    vectors++;
    if ({hi, lo} !== 32'hFFFE_0001) begin
      miscompares++; $display("FAIL b2b_first_product: got %h want fffe0001", {hi, lo});
    end
    issue(16'h0002, 16'h8000);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept: busy got %b want 1", busy);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second_latency: got %0d done=%b want 16 done=1", cyc, done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0001_0000) begin
      miscompares++; $display("FAIL b2b_second_product: got %h want 00010000", {hi, lo});
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    int seen_done;
    issue(16'h1234, 16'h0010);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL flush_abort: busy/done got %b want 00", {busy, done});
    end
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      @(negedge clk);
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++; $display("FAIL flush_quiet: active cycles got %0d want 0", seen_done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0001_0000) begin
      miscompares++; $display("FAIL flush_hilo_hold: got %h want 00010000", {hi, lo});
    end
  endtask

  task automatic test_start_in_run;
    int cyc;
    issue(16'h0003, 16'h0004);
    repeat (2) @(negedge clk);
    issue(16'h00FF, 16'h00FF);
    wait_done(cyc);
    vectors++;
    if (cyc + 3 !== 16 || done !== 1'b1) begin
      miscompares++; $display("FAIL run_start_latency: got %0d done=%b want 16 done=1", cyc + 3, done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0000_000C) begin
      miscompares++; $display("FAIL run_start_ignored: got %h want 0000000c", {hi, lo});
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL run_start_no_requeue: busy got %b want 0", busy);
    end
  endtask

  task automatic test_flush_start_idle;
    int active;
    val1 = 16'h0005; val2 = 16'h0005; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    active = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1 || done === 1'b1) active++;
      @(negedge clk);
    end
    vectors++;
    if (active !== 0) begin
      miscompares++; $display("FAIL flush_start_drop: active cycles got %0d want 0", active);
    end
    vectors++;
    if ({hi, lo} !== 32'h0000_000C) begin
      miscompares++; $display("FAIL flush_start_hilo: got %h want 0000000c", {hi, lo});
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    issue(16'h1111, 16'h2222);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, hi, lo} !== 34'h0) begin
      miscompares++;
      $display("FAIL rst_mid_run: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'd7, 16'd9);
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || done !== 1'b1) begin
      miscompares++; $display("FAIL rst_recover_latency: got %0d done=%b want 16 done=1", cyc, done);
    end
    vectors++;
    if ({hi, lo} !== 32'h0000_003F) begin
      miscompares++; $display("FAIL rst_recover_product: got %h want 0000003f", {hi, lo});
    end
    @(negedge clk);
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed;
    int cyc;
    is_signed = 1'b1;
    issue(16'hFFFE, 16'h0003);
    wait_done(cyc);
    vectors++;
    if (cyc !== 16 || {hi, lo} !== 32'hFFFF_FFFA) begin
      miscompares++; $display("FAIL signed_neg: cyc=%0d got %h want 16 fffffffa", cyc, {hi, lo});
    end
    @(negedge clk);
    is_signed = 1'b0;
    issue(16'hFFFE, 16'h0003);
    wait_done(cyc);
    vectors++;
    if ({hi, lo} !== 32'h0002_FFFA) begin
      miscompares++; $display("FAIL unsigned_same_ops: got %h want 0002fffa", {hi, lo});
    end
    @(negedge clk);
    is_signed = 1'b1;
    issue(16'h8000, 16'h8000);
    wait_done(cyc);
    vectors++;
    if ({hi, lo} !== 32'h4000_0000) begin
      miscompares++; $display("FAIL signed_min_sq: got %h want 40000000", {hi, lo});
    end
    @(negedge clk);
    issue(16'h8000, 16'h0001);
    wait_done(cyc);
    vectors++;
    if ({hi, lo} !== 32'hFFFF_8000) begin
      miscompares++; $display("FAIL signed_min_x1: got %h want ffff8000", {hi, lo});
    end
    is_signed = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_flush();
    test_start_in_run();
    test_flush_start_idle();
    test_reset_mid_run();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
